// File: rtl/fp16_to_int16_cvt_pkg.sv
// Shared constants, types and operand classification for the FP16 -> int16 converter.
package fp16_to_int16_cvt_pkg;

  // FP16 layout: [15] sign, [EMSB:FMSB+1] exponent, [FMSB:0] significand.
  localparam int unsigned FP16      = 16;
  localparam int unsigned EMSB      = 14;
  localparam int unsigned FMSB      = 9;
  localparam int unsigned FP16_BIAS = 15;

  localparam int unsigned ExpW = EMSB - FMSB;
  localparam int unsigned SigW = FMSB + 1;
  localparam int unsigned MagW = 15;

  localparam logic [FP16-1:0] INT16_MAX = 16'h7FFF;
  localparam logic [FP16-1:0] INT16_MIN = 16'h8000;

  // Exponent codes with special meaning.
  localparam logic [ExpW-1:0] ExpBias = ExpW'(FP16_BIAS);
  localparam logic [ExpW-1:0] ExpSat  = ExpW'(30);
  localparam logic [ExpW-1:0] ExpInf  = ExpW'(31);

  // Result class decided in S1, acted on in S2.
  typedef enum logic [1:0] {
    KindNum,  // in range, magnitude is valid
    KindOvf,  // saturate by sign, overflow flag
    KindNan,  // zero result, invalid flag
    KindMin   // exactly -32768, representable
  } kind_e;

  typedef struct packed {
    logic            sign;
    kind_e           kind;
    logic [MagW-1:0] mag;
    logic            sticky;
  } s1_t;

  // Classify an operand by its exponent/significand.
  function automatic kind_e classify(input logic            sign,
                                     input logic [ExpW-1:0] exp,
                                     input logic [SigW-1:0] sig);
    kind_e k;
    k = KindNum;
    if (exp == ExpInf) begin
      k = (sig != '0) ? KindNan : KindOvf;
    end else if (exp == ExpSat) begin
      // |x| >= 32768: only -32768 itself is representable.
      k = (sign && (sig == '0)) ? KindMin : KindOvf;
    end
    return k;
  endfunction

endpackage

// File: rtl/fp16_mag_shift.sv
// Combinational S1 datapath: exponent-driven shift of the mantissa into a
// 15-bit integer magnitude plus the sticky (discarded fraction) bit.
module fp16_mag_shift
  import fp16_to_int16_cvt_pkg::*;
(
  input  logic [ExpW-1:0] exp,
  input  logic [SigW-1:0] sig,
  output logic [MagW-1:0] mag,
  output logic            sticky
);

  logic [SigW:0]   mant;
  logic [3:0]      e;
  // Fixed point: [24:10] integer part, [9:0] fraction part.
  logic [24:0]     fixed;

  // Shift mantissa by the unbiased exponent; fraction bits form the sticky bit.
  always_comb begin
    mant   = {1'b1, sig};
    e      = '0;
    fixed  = '0;
    mag    = '0;
    sticky = 1'b0;
    if (exp < ExpBias) begin
      // |x| < 1 (including zero/subnormal): truncates to zero.
      sticky = (exp != '0) || (sig != '0);
    end else if (exp < ExpSat) begin
      e      = 4'(exp - ExpBias);
      fixed  = {14'd0, mant} << e;
      mag    = fixed[24:10];
      sticky = |fixed[9:0];
    end
  end

endmodule

// File: rtl/fp16_to_int16_cvt.sv
// Two-stage FP16 -> int16 converter, truncating toward zero.
// S1 decodes and shifts the operand; S2 negates, saturates and raises flags.
module fp16_to_int16_cvt
  import fp16_to_int16_cvt_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FP16-1:0] i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FP16-1:0] o,
  output logic            overflow,
  output logic            invalid,
  output logic            inexact
);

  logic            s1_valid_q;
  s1_t             s1_d, s1_q;
  logic            s2_valid_q;
  logic [FP16-1:0] o_d, o_q;
  logic            overflow_d, overflow_q;
  logic            invalid_d, invalid_q;
  logic            inexact_d, inexact_q;
  logic            s2_en;
  logic [MagW-1:0] mag_w;
  logic            sticky_w;
  logic [FP16-1:0] mag16;

  // S2 may load when empty or when its result leaves this cycle.
  assign s2_en    = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_en;

  fp16_mag_shift u_mag_shift (
    .exp    (i[EMSB:FMSB+1]),
    .sig    (i[FMSB:0]),
    .mag    (mag_w),
    .sticky (sticky_w)
  );

  // S1 next-state: classify operand and capture shifted magnitude.
  always_comb begin
    s1_d        = '0;
    s1_d.sign   = i[FP16-1];
    s1_d.kind   = classify(i[FP16-1], i[EMSB:FMSB+1], i[FMSB:0]);
    s1_d.mag    = mag_w;
    s1_d.sticky = sticky_w;
  end

  // S1 pipeline register; captures only on an accepted input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_q <= s1_d;
      end
    end
  end

  // S2 next-state: sign application, saturation and flag selection.
  always_comb begin
    mag16      = {1'b0, s1_q.mag};
    o_d        = '0;
    overflow_d = 1'b0;
    invalid_d  = 1'b0;
    inexact_d  = 1'b0;
    unique case (s1_q.kind)
      KindNum: begin
        // Negating a zero magnitude gives zero, so -0 maps to 0x0000.
        o_d       = s1_q.sign ? 16'(-mag16) : mag16;
        inexact_d = s1_q.sticky;
      end
      KindOvf: begin
        o_d        = s1_q.sign ? INT16_MIN : INT16_MAX;
        overflow_d = 1'b1;
      end
      KindNan: begin
        o_d       = '0;
        invalid_d = 1'b1;
      end
      KindMin: begin
        o_d = INT16_MIN;
      end
    endcase
  end

  // S2 output register; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      o_q        <= '0;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
      inexact_q  <= 1'b0;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        o_q        <= o_d;
        overflow_q <= overflow_d;
        invalid_q  <= invalid_d;
        inexact_q  <= inexact_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign o         = o_q;
  assign overflow  = overflow_q;
  assign invalid   = invalid_q;
  assign inexact   = inexact_q;

endmodule

// File: tb/tb_fp16_to_int16_cvt.sv
// Directed self-checking bench for fp16_to_int16_cvt.
module tb_fp16_to_int16_cvt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] i_w = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] o;
  logic        overflow;
  logic        invalid;
  logic        inexact;

  int n_cmp = 0;
  int n_err = 0;

  // fl = {overflow, invalid, inexact}
  typedef struct {
    logic [15:0] x;
    logic [15:0] o;
    logic [2:0]  fl;
  } vec_t;

  fp16_to_int16_cvt dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i         (i_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .overflow  (overflow),
    .invalid   (invalid),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {13'd0, overflow, invalid, inexact, o};
  endfunction

  function automatic logic [31:0] expv(input vec_t v);
    return {13'd0, v.fl, v.o};
  endfunction

  // One isolated conversion: accept, no result after 1 cycle, result after 2.
  task automatic run_one(input vec_t v, input string tag);
    @(posedge clk); #1;
    in_valid = 1'b1;
    i_w      = v.x;
    check_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    i_w      = 16'hDEAD;
    check_eq({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_vld"}, 32'(out_valid), 32'd1);
    check_eq(tag, obs(), expv(v));
  endtask

  vec_t vecs[21] = '{
    '{16'h3C00, 16'h0001, 3'b000},  // 1.0
    '{16'hC500, 16'hFFFB, 3'b000},  // -5.0
    '{16'h7800, 16'h7FFF, 3'b100},  // 32768
    '{16'hF800, 16'h8000, 3'b000},  // -32768
    '{16'h7C00, 16'h7FFF, 3'b100},  // +inf
    '{16'h3E00, 16'h0001, 3'b001},  // 1.5
    '{16'h3400, 16'h0000, 3'b001},  // 0.25
    '{16'h7E00, 16'h0000, 3'b010},  // NaN
    '{16'h0000, 16'h0000, 3'b000},  // +0
    '{16'h8000, 16'h0000, 3'b000},  // -0
    '{16'h0001, 16'h0000, 3'b001},  // smallest subnormal
    '{16'h77FF, 16'h7FF0, 3'b000},  // 32752
    '{16'hF7FF, 16'h8010, 3'b000},  // -32752
    '{16'hF801, 16'h8000, 3'b100},  // just below -32768
    '{16'hFC00, 16'h8000, 3'b100},  // -inf
    '{16'hBE00, 16'hFFFF, 3'b001},  // -1.5
    '{16'h3BFF, 16'h0000, 3'b001},  // just below 1.0
    '{16'h4E40, 16'h0019, 3'b000},  // 25.0
    '{16'h6400, 16'h0400, 3'b000},  // 1024.0 (e = 10)
    '{16'hFDFF, 16'h0000, 3'b010},  // negative NaN
    '{16'hB400, 16'h0000, 3'b001}   // -0.25
  };

  vec_t strm[8] = '{
    '{16'h3C00, 16'h0001, 3'b000},
    '{16'hC500, 16'hFFFB, 3'b000},
    '{16'h4000, 16'h0002, 3'b000},
    '{16'h4E40, 16'h0019, 3'b000},
    '{16'h6400, 16'h0400, 3'b000},
    '{16'hBE00, 16'hFFFF, 3'b001},
    '{16'h77FF, 16'h7FF0, 3'b000},
    '{16'h3E00, 16'h0001, 3'b001}
  };

  initial begin
    logic [31:0] expq[$];
    int          idx;
    int          got;
    bit          prev_fire;
    bit          saw_bp;
    vec_t        v2;

    // Reset state
    #12;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_outputs", obs(), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // Isolated vectors
    for (int k = 0; k < 21; k++) begin
      run_one(vecs[k], $sformatf("vec%0d_%h", k, vecs[k].x));
    end

    // Back-to-back stream with a 3-cycle consumer stall
    idx       = 0;
    got       = 0;
    prev_fire = 1'b0;
    saw_bp    = 1'b0;
    for (int k = 0; k < 8; k++) expq.push_back(expv(strm[k]));
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(posedge clk); #1;
      if (prev_fire) idx++;
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid  = (idx < 8);
      if (idx < 8) i_w = strm[idx].x;
      #1;
      prev_fire = in_valid && in_ready;
      if (!in_ready) saw_bp = 1'b1;
      if (out_valid) begin
        if (expq.size() == 0) begin
          check_eq("stream_extra", 32'd1, 32'd0);
        end else begin
          check_eq($sformatf("stream_res%0d", got), obs(), expq[0]);
          if (out_ready) begin
            void'(expq.pop_front());
            got++;
          end
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("stream_count", 32'(got), 32'd8);
    check_eq("stream_backpressure", 32'(saw_bp), 32'd1);
    @(posedge clk); #1;
    check_eq("stream_drained", 32'(out_valid), 32'd0);

    // Reset with two words in flight
    @(posedge clk); #1;
    in_valid = 1'b1;
    i_w      = 16'h3C00;
    @(posedge clk); #1;
    i_w      = 16'h4400;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_outputs", obs(), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_eq($sformatf("postrst_idle%0d", k), 32'(out_valid), 32'd0);
    end
    check_eq("postrst_in_ready", 32'(in_ready), 32'd1);
    v2 = '{16'h4000, 16'h0002, 3'b000};
    run_one(v2, "postrst_2p0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
